// File: rtl/note_cmd_decoder.sv
// Pulls 32-bit note commands from a FIFO and drives the tone period, gate and
// envelope trigger pulses; WAIT commands stall the command stream for n clocks.
module note_cmd_decoder #(
  parameter int PERIOD_W = 23,
  parameter int WAIT_W   = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  output logic                fifo_rden,
  input  logic [31:0]         fifo_data,
  output logic [PERIOD_W-1:0] period,
  output logic                gate,
  output logic                note_on,
  output logic                note_off,
  output logic [7:0]          err_count
);

  localparam int ARG_W = 23;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] OP_LEGACY = 2'b00;
  localparam logic [1:0] OP_ON     = 2'b01;
  localparam logic [1:0] OP_OFF    = 2'b10;
  localparam logic [1:0] OP_WAIT   = 2'b11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]          r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_gate;
  logic                r_note_on;
  logic                r_note_off;
  logic [7:0]          r_err_count;

  logic [1:0]          w_op;
  logic                w_rsvd_bad;
  logic [ARG_W-1:0]    w_arg;
  logic [PERIOD_W-1:0] w_per;
  logic [WAIT_W-1:0]   w_wait;
  logic                w_do_on;
  logic                w_do_off;
  logic                w_reject;
  logic                w_do_wait;

  assign w_op       = fifo_data[31:30];
  assign w_rsvd_bad = |fifo_data[29:23];
  assign w_arg      = fifo_data[22:0];
  assign w_per      = PERIOD_W'(w_arg);
  assign w_wait     = WAIT_W'(w_arg);

  // Pop only from IDLE, so a word is consumed at most every other clock.
  assign fifo_rden = (r_state == S_IDLE) && !fifo_empty && !rst;

  // Decode of the word presented during FETCH; ignored in other states.
  always_comb begin
    w_do_on   = 1'b0;
    w_do_off  = 1'b0;
    w_reject  = 1'b0;
    w_do_wait = 1'b0;
    if (w_rsvd_bad) begin
      w_reject = 1'b1;
    end else begin
      case (w_op)
        OP_LEGACY: begin
          w_do_on  = (w_per != '0);
          w_do_off = (w_per == '0);
        end
        OP_ON: begin
          w_do_on  = (w_per != '0);
          w_reject = (w_per == '0);
        end
        OP_OFF:  w_do_off  = 1'b1;
        OP_WAIT: w_do_wait = (w_wait != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_period    <= '0;
      r_gate      <= 1'b0;
      r_note_on   <= 1'b0;
      r_note_off  <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state    <= w_do_wait ? S_WAIT : S_IDLE;
          // n-1 so that WAIT lasts exactly n clocks including the zero count.
          r_wait_cnt <= w_wait - WAIT_W'(1);
          if (w_reject) r_err_count <= sat_inc8(r_err_count);
          if (w_do_on && (!r_gate || (w_per != r_period))) begin
            r_period  <= w_per;
            r_gate    <= 1'b1;
            r_note_on <= 1'b1;
          end
          if (w_do_off && r_gate) begin
            r_period   <= '0;
            r_gate     <= 1'b0;
            r_note_off <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) r_state <= S_IDLE;
          else                  r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign period    = r_period;
  assign gate      = r_gate;
  assign note_on   = r_note_on;
  assign note_off  = r_note_off;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_note_cmd_decoder.sv
// Directed bench for note_cmd_decoder: an array-backed FIFO model feeds command
// words, monitors log pop cycles and pulse counts, each task checks its scenario.
module tb_note_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] fifo_data = 32'd0;
  logic [22:0] period;
  logic        gate;
  logic        note_on;
  logic        note_off;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];
  int          rden_cyc [0:1023];
  int          n_push = 0;
  int          n_pop  = 0;
  int          cyc    = 0;
  int          n_on   = 0;
  int          n_off  = 0;
  int          n_both = 0;

  note_cmd_decoder #(.PERIOD_W(23), .WAIT_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rden (fifo_rden),
    .fifo_data (fifo_data),
    .period    (period),
    .gate      (gate),
    .note_on   (note_on),
    .note_off  (note_off),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (n_push == n_pop);

  // FIFO model: data appears on the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_data       <= mem[n_pop];
      rden_cyc[n_pop] <= cyc;
      n_pop           <= n_pop + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (note_on)  n_on  <= n_on + 1;
    if (note_off) n_off <= n_off + 1;
    if (note_on && note_off) n_both <= n_both + 1;
  end

  task automatic push(input logic [31:0] w);
    mem[n_push] = w;
    n_push = n_push + 1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    run(3);
    push(32'h4000_0100);
    #1;
    n_checks++; if (fifo_rden !== 1'b0) begin $display("FAIL reset_rden: got %b expected 0", fifo_rden); n_fail++; end
    n_checks++; if (period !== 23'd0) begin $display("FAIL reset_period: got %h expected 0", period); n_fail++; end
    n_checks++; if (gate !== 1'b0 || note_on !== 1'b0 || note_off !== 1'b0) begin
      $display("FAIL reset_flags: got gate=%b on=%b off=%b expected 000", gate, note_on, note_off); n_fail++; end
    n_checks++; if (err_count !== 8'd0) begin $display("FAIL reset_err: got %0d expected 0", err_count); n_fail++; end
  endtask

  task automatic test_basic_note();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_rden !== 1'b1) begin $display("FAIL basic_rden: got %b expected 1", fifo_rden); n_fail++; end
    @(negedge clk);
    n_checks++; if (fifo_rden !== 1'b0 || note_on !== 1'b0) begin
      $display("FAIL basic_fetch: got rden=%b on=%b expected 0 0", fifo_rden, note_on); n_fail++; end
    @(negedge clk);
    n_checks++; if (note_on !== 1'b1 || period !== 23'h100 || gate !== 1'b1) begin
      $display("FAIL basic_note: got on=%b period=%h gate=%b expected 1 100 1", note_on, period, gate); n_fail++; end
    @(negedge clk);
    n_checks++; if (note_on !== 1'b0 || gate !== 1'b1) begin
      $display("FAIL basic_pulse_width: got on=%b gate=%b expected 0 1", note_on, gate); n_fail++; end
  endtask

  task automatic test_note_seq();
    int on0, off0;
    do_reset();
    on0 = n_on; off0 = n_off;
    push(32'h4000_0100); push(32'h4000_0100); push(32'h4000_0080); push(32'h8000_0000);
    run(14);
    n_checks++; if (n_on - on0 !== 2) begin $display("FAIL seq_on_count: got %0d expected 2", n_on - on0); n_fail++; end
    n_checks++; if (n_off - off0 !== 1) begin $display("FAIL seq_off_count: got %0d expected 1", n_off - off0); n_fail++; end
    n_checks++; if (period !== 23'd0 || gate !== 1'b0) begin
      $display("FAIL seq_final: got period=%h gate=%b expected 0 0", period, gate); n_fail++; end
  endtask

  task automatic test_legacy();
    int on0, off0;
    do_reset();
    on0 = n_on; off0 = n_off;
    push(32'h0000_0200);
    run(6);
    n_checks++; if (n_on - on0 !== 1 || period !== 23'h200 || gate !== 1'b1) begin
      $display("FAIL legacy_on: got ons=%0d period=%h gate=%b expected 1 200 1", n_on - on0, period, gate); n_fail++; end
    push(32'h0000_0000);
    run(6);
    n_checks++; if (n_off - off0 !== 1 || period !== 23'd0 || gate !== 1'b0) begin
      $display("FAIL legacy_off: got offs=%0d period=%h gate=%b expected 1 0 0", n_off - off0, period, gate); n_fail++; end
    push(32'h0000_0000);
    run(6);
    n_checks++; if (n_off - off0 !== 1 || n_on - on0 !== 1) begin
      $display("FAIL legacy_idle_off: got offs=%0d ons=%0d expected 1 1", n_off - off0, n_on - on0); n_fail++; end
  endtask

  task automatic test_wait();
    int b, on0, off0;
    do_reset();
    on0 = n_on; off0 = n_off; b = n_push;
    push(32'hC000_0005); push(32'h4000_0010);
    run(14);
    n_checks++; if (n_pop !== b + 2) begin $display("FAIL wait_pops: got %0d expected %0d", n_pop, b + 2); n_fail++; end
    else begin
      n_checks++; if (rden_cyc[b+1] - rden_cyc[b] !== 7) begin
        $display("FAIL wait_gap: got %0d expected 7", rden_cyc[b+1] - rden_cyc[b]); n_fail++; end
    end
    n_checks++; if (n_on - on0 !== 1 || n_off - off0 !== 0 || period !== 23'h10) begin
      $display("FAIL wait_pulses: got ons=%0d offs=%0d period=%h expected 1 0 10", n_on - on0, n_off - off0, period); n_fail++; end
    b = n_push;
    push(32'hC000_0000); push(32'h4000_0020);
    run(8);
    n_checks++; if (n_pop !== b + 2 || rden_cyc[b+1] - rden_cyc[b] !== 2) begin
      $display("FAIL wait0_gap: got pops=%0d gap=%0d expected %0d 2", n_pop, rden_cyc[b+1] - rden_cyc[b], b + 2); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    b = n_push;
    push(32'h4000_0011); push(32'h4000_0022); push(32'h4000_0033);
    run(10);
    n_checks++; if (rden_cyc[b+1] - rden_cyc[b] !== 2 || rden_cyc[b+2] - rden_cyc[b+1] !== 2) begin
      $display("FAIL b2b_gap: got %0d %0d expected 2 2", rden_cyc[b+1] - rden_cyc[b], rden_cyc[b+2] - rden_cyc[b+1]); n_fail++; end
    n_checks++; if (period !== 23'h33 || gate !== 1'b1) begin
      $display("FAIL b2b_final: got period=%h gate=%b expected 33 1", period, gate); n_fail++; end
  endtask

  task automatic test_rejects();
    int on0, off0;
    do_reset();
    on0 = n_on; off0 = n_off;
    push(32'h4080_0010); push(32'h4000_0000);
    run(8);
    n_checks++; if (err_count !== 8'd2 || n_on - on0 !== 0 || n_off - off0 !== 0 || gate !== 1'b0) begin
      $display("FAIL reject_basic: got err=%0d ons=%0d offs=%0d gate=%b expected 2 0 0 0", err_count, n_on - on0, n_off - off0, gate); n_fail++; end
    push(32'h4000_0040); push(32'h4080_0050);
    run(8);
    n_checks++; if (err_count !== 8'd3 || period !== 23'h40 || gate !== 1'b1) begin
      $display("FAIL reject_hold: got err=%0d period=%h gate=%b expected 3 40 1", err_count, period, gate); n_fail++; end
    for (int i = 0; i < 300; i++) push(32'h0080_0000);
    run(620);
    n_checks++; if (err_count !== 8'd255) begin $display("FAIL reject_saturate: got %0d expected 255", err_count); n_fail++; end
  endtask

  task automatic test_reset_midwait();
    int b;
    do_reset();
    push(32'h4000_0070); push(32'hC000_03E8);
    run(12);
    b = n_push;
    push(32'h4000_0030);
    run(4);
    n_checks++; if (n_pop !== b || fifo_rden !== 1'b0) begin
      $display("FAIL midwait_hold: got pops=%0d rden=%b expected %0d 0", n_pop, fifo_rden, b); n_fail++; end
    rst = 1'b1;
    #1;
    n_checks++; if (fifo_rden !== 1'b0) begin $display("FAIL midwait_rst_rden: got %b expected 0", fifo_rden); n_fail++; end
    @(negedge clk);
    n_checks++; if (period !== 23'd0 || gate !== 1'b0 || fifo_rden !== 1'b0) begin
      $display("FAIL midwait_rst_out: got period=%h gate=%b rden=%b expected 0 0 0", period, gate, fifo_rden); n_fail++; end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_rden !== 1'b1) begin $display("FAIL midwait_resume: got %b expected 1", fifo_rden); n_fail++; end
    run(4);
    n_checks++; if (period !== 23'h30 || gate !== 1'b1) begin
      $display("FAIL midwait_after: got period=%h gate=%b expected 30 1", period, gate); n_fail++; end
  endtask

  task automatic test_exclusive();
    n_checks++; if (n_both !== 0) begin $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_both); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic_note();
    test_note_seq();
    test_legacy();
    test_wait();
    test_back_to_back();
    test_rejects();
    test_reset_midwait();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_cmd_decoder.md
NOTE_CMD_DECODER -- requirements
Module: note_cmd_decoder

Interface
REQ-001 The module SHALL have parameter PERIOD_W, default 23, giving the width of the tone period field and output.
REQ-002 The module SHALL have parameter WAIT_W, default 23, giving the width of the wait-count field.
REQ-003 clk  input  1  the single clock for all logic (the synthesis clock domain).
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 fifo_empty  input  1  high when the upstream 32-bit command FIFO holds no word.
REQ-006 fifo_rden  output  1  pop strobe to the FIFO; standard FIFO, data valid on the cycle after the pop.
REQ-007 fifo_data  input  32  FIFO read data.
REQ-008 period  output  PERIOD_W  tone period for the square-wave generator; 0 means silent.
REQ-009 gate  output  1  high while a note is sounding.
REQ-010 note_on  output  1  one-cycle pulse to the envelope generator.
REQ-011 note_off  output  1  one-cycle pulse to the envelope generator.
REQ-012 err_count  output  8  count of rejected words; saturates at 255.

Function
REQ-013 The command word SHALL be decoded as: [31:30] opcode; [29:23] reserved, must be 0; [22:0] argument, zero-extended or truncated to the parameter width.
REQ-014 The opcodes SHALL be: 00 = legacy period (argument nonzero → NOTE_ON; argument zero → NOTE_OFF), 01 = NOTE_ON(argument), 10 = NOTE_OFF (argument ignored), 11 = WAIT(argument clocks).
REQ-015 The FSM SHALL have three states: IDLE, FETCH and WAIT.
REQ-016 In IDLE, fifo_rden SHALL be combinationally high when fifo_empty=0 and rst=0, and the FSM SHALL move to FETCH; otherwise the FSM stays in IDLE.
REQ-017 In FETCH, fifo_data SHALL be sampled and decoded, and the FSM SHALL return to IDLE unless the word is a WAIT with a nonzero argument, in which case it enters WAIT.
REQ-018 fifo_rden SHALL be 0 in FETCH and in WAIT.
REQ-019 Peak throughput SHALL be one word per 2 clocks.
REQ-020 The outputs period, gate, note_on, note_off and err_count SHALL be registered and update at the end of the FETCH cycle, i.e. visible 2 clocks after the fifo_rden cycle.
REQ-021 NOTE_ON(p), p≠0, with gate=0 SHALL set period=p, set gate=1 and pulse note_on.
REQ-022 NOTE_ON(p) with gate=1 and p≠period SHALL set period=p and pulse note_on (retrigger); gate stays 1.
REQ-023 NOTE_ON(p) with gate=1 and p=period SHALL produce no pulse and no change.
REQ-024 NOTE_ON(0) through opcode 01 SHALL be treated as a reject: err_count increments and state is unchanged.
REQ-025 NOTE_OFF with gate=1 SHALL set gate=0, set period=0 and pulse note_off.
REQ-026 NOTE_OFF with gate=0 SHALL be ignored with no pulse.
REQ-027 note_on and note_off SHALL never both be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-028 A word with nonzero reserved bits SHALL be rejected: err_count increments, and period, gate and the pulses are unchanged.
REQ-029 err_count SHALL hold at 255 once it reaches 255.
REQ-030 WAIT(n), n≥1, SHALL load a down-counter with n-1, hold in WAIT for exactly n clocks, then return to IDLE; the next fifo_rden occurs no earlier than n+2 clocks after the WAIT word's rden.
REQ-031 WAIT(0) SHALL behave as a no-op and return directly to IDLE.
REQ-032 If fifo_empty is high in IDLE, the FSM SHALL idle with no pop, and all outputs hold except that pulses are 0.

Reset
REQ-033 On rst=1 at a clock edge, the FSM SHALL go to IDLE, with period=0, gate=0, note_on=0, note_off=0 and err_count=0.
REQ-034 fifo_rden SHALL be 0 throughout reset.
REQ-035 Reset during FETCH SHALL discard the popped word, and reset during WAIT SHALL abandon the remaining count.
REQ-036 rst SHALL take priority over all decode activity in the same cycle.

Verification
REQ-037 Basic note: FIFO holds 0x4000_0100 → rden pulse, note_on pulse 2 clocks later, period=0x100, gate=1.
REQ-038 Note sequence: 0x4000_0100, 0x4000_0100, 0x4000_0080, 0x8000_0000 → exactly 2 note_on pulses and 1 note_off pulse; final period=0, gate=0.
REQ-039 Legacy opcode: 0x0000_0200 then 0x0000_0000 → note_on with period=0x200, then note_off; a second 0x0000_0000 produces no pulse.
REQ-040 Wait: 0xC000_0005 followed by 0x4000_0010 → the second rden occurs exactly 7 clocks after the first, and the WAIT word produces no pulse.
REQ-041 Rejects: 0x4080_0010 and 0x4000_0000 → err_count=2 with no pulses; 300 bad words → err_count=255.
REQ-042 Reset mid-wait: rst asserted during WAIT(1000) → outputs 0, FSM in IDLE, and a pop resumes 1 clock after rst deasserts if fifo_empty=0.
